// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC poller: FSM states, the packed mm:ss
// BCD sample layout and the seven-segment patterns ({g,f,e,d,c,b,a}, active high).
package rtc_pkg;

  typedef enum logic {IDLE, REQ} poller_state_t;

  typedef struct packed {
    logic [3:0] min_hi;
    logic [3:0] min_lo;
    logic [3:0] sec_hi;
    logic [3:0] sec_lo;
  } bcd_time_t;

  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Entry [n] is the pattern for digit n; entry 9 is written first.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101,
    7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
  };

  function automatic logic bcd_valid(input bcd_time_t t);
    return (t.sec_lo <= 4'd9) && (t.sec_hi <= 4'd5) &&
           (t.min_lo <= 4'd9) && (t.min_hi <= 4'd5);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to seven-segment decoder; non-decimal codes show blank.
module bcd_to_7seg
  import rtc_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = (digit <= 4'd9) ? SEG_TABLE[digit] : SEG_BLANK;

endmodule

// File: rtl/rtc_poller.sv
// Periodically reads an RTC time register over the memory bus, keeps the last
// valid mm:ss sample and scans it onto a 4-digit multiplexed display.
module rtc_poller
  import rtc_pkg::*;
#(
  parameter logic [31:0] RTC_ADDR   = 32'h0000_8000,
  parameter int unsigned POLL_COUNT = 1000000,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned SCAN_COUNT = 10000
) (
  input  logic        clk_in,
  input  logic        reset_n,
  output logic [31:0] address_out,
  output logic        sel_out,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic [31:0] read_value_in,
  input  logic        ready_in,
  output logic [15:0] time_out,
  output logic        valid_out,
  output logic        timeout_err_out,
  output logic        bcd_err_out,
  output logic [6:0]  seg_out,
  output logic [3:0]  dig_out
);

  localparam int PW = cnt_width(POLL_COUNT);
  localparam int TW = cnt_width(TIMEOUT);
  localparam int SW = cnt_width(SCAN_COUNT);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_COUNT - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_COUNT - 1);

  poller_state_t state, state_d;
  logic [PW-1:0] poll_cnt, poll_d;
  logic [TW-1:0] wait_cnt, wait_d;
  logic          capture, timeout_hit;
  bcd_time_t     sample, time_q;
  logic          sample_ok;
  logic          valid_q, timeout_err_q, bcd_err_q;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    nibble;
  logic [6:0]    dec_seg;
  logic          unused_upper;

  assign sample       = bcd_time_t'(read_value_in[15:0]);
  assign sample_ok    = bcd_valid(sample);
  assign unused_upper = ^read_value_in[31:16];

  always_comb begin
    state_d     = state;
    poll_d      = poll_cnt;
    wait_d      = wait_cnt;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        wait_d = '0;
        if (poll_cnt == POLL_LAST) begin
          poll_d  = '0;
          state_d = REQ;
        end else begin
          poll_d = poll_cnt + 1'b1;
        end
      end
      REQ: begin
        poll_d = '0;
        // A same-cycle ready takes priority over the timeout.
        if (ready_in) begin
          capture = 1'b1;
          wait_d  = '0;
          state_d = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_hit = 1'b1;
          wait_d      = '0;
          state_d     = IDLE;
        end else begin
          wait_d = wait_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      poll_cnt      <= '0;
      wait_cnt      <= '0;
      time_q        <= '0;
      valid_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      bcd_err_q     <= 1'b0;
    end else begin
      state    <= state_d;
      poll_cnt <= poll_d;
      wait_cnt <= wait_d;
      if (capture) begin
        if (sample_ok) begin
          time_q  <= sample;
          valid_q <= 1'b1;
        end else begin
          bcd_err_q <= 1'b1;
        end
      end
      if (timeout_hit) timeout_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    nibble = time_q.sec_lo;
    case (digit_idx)
      2'd0: nibble = time_q.sec_lo;
      2'd1: nibble = time_q.sec_hi;
      2'd2: nibble = time_q.min_lo;
      2'd3: nibble = time_q.min_hi;
      default: nibble = time_q.sec_lo;
    endcase
  end

  bcd_to_7seg u_dec (
    .digit (nibble),
    .seg   (dec_seg)
  );

  // sel_out is decoded from the state register so reset drops it asynchronously.
  assign sel_out         = (state == REQ);
  assign address_out     = sel_out ? RTC_ADDR : 32'h0;
  assign write_mask_out  = 4'b0000;
  assign write_value_out = 32'h0;
  assign time_out        = time_q;
  assign valid_out       = valid_q;
  assign timeout_err_out = timeout_err_q;
  assign bcd_err_out     = bcd_err_q;
  assign dig_out         = ~(4'b0001 << digit_idx);
  assign seg_out         = valid_q ? dec_seg : SEG_DASH;

endmodule

// File: tb/tb_rtc_poller.sv
// Directed self-checking bench for rtc_poller with a responder whose ready
// delay (in sel cycles) is programmable; POLL=8, TIMEOUT=4, SCAN=2.
module tb_rtc_poller;

  localparam logic [31:0] ADDR = 32'h0000_8000;
  localparam logic [6:0]  DASH = 7'b1000000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] address_out;
  logic        sel_out;
  logic [3:0]  write_mask_out;
  logic [31:0] write_value_out;
  logic [31:0] read_value = 32'h0;
  logic        ready_in;
  logic [15:0] time_out;
  logic        valid_out;
  logic        timeout_err_out;
  logic        bcd_err_out;
  logic [6:0]  seg_out;
  logic [3:0]  dig_out;

  int checks = 0;
  int failures = 0;
  int ready_delay = 0;
  int sel_cycles = 0;

  rtc_poller #(
    .RTC_ADDR   (ADDR),
    .POLL_COUNT (8),
    .TIMEOUT    (4),
    .SCAN_COUNT (2)
  ) dut (
    .clk_in          (clk),
    .reset_n         (reset_n),
    .address_out     (address_out),
    .sel_out         (sel_out),
    .write_mask_out  (write_mask_out),
    .write_value_out (write_value_out),
    .read_value_in   (read_value),
    .ready_in        (ready_in),
    .time_out        (time_out),
    .valid_out       (valid_out),
    .timeout_err_out (timeout_err_out),
    .bcd_err_out     (bcd_err_out),
    .seg_out         (seg_out),
    .dig_out         (dig_out)
  );

  always #5 clk = ~clk;

  // Responder: ready is asserted once sel has been high for ready_delay cycles.
  always @(posedge clk) sel_cycles <= sel_out ? sel_cycles + 1 : 0;
  assign ready_in = sel_out && (sel_cycles >= ready_delay);

  task automatic do_reset(input int delay, input logic [31:0] data);
    reset_n     = 1'b0;
    ready_delay = delay;
    read_value  = data;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_sel(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!sel_out && cycles < 50);
  endtask

  task automatic count_sel(output int n);
    n = 1;
    while (n < 50) begin
      @(negedge clk);
      if (!sel_out) break;
      n++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    read_value = 32'h0000_1234;
    @(negedge clk);
    checks++; if (sel_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_sel: got %b want 0", sel_out); end
    checks++; if (address_out !== 32'h0) begin failures++; $display("[TB] FAIL reset_addr: got %h want 0", address_out); end
    checks++; if (time_out !== 16'h0) begin failures++; $display("[TB] FAIL reset_time: got %h want 0", time_out); end
    checks++; if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b want 0", valid_out); end
    checks++; if ({timeout_err_out, bcd_err_out} !== 2'b00) begin failures++; $display("[TB] FAIL reset_errs: got %b want 00", {timeout_err_out, bcd_err_out}); end
    checks++; if (dig_out !== 4'b1110) begin failures++; $display("[TB] FAIL reset_dig: got %b want 1110", dig_out); end
    checks++; if (seg_out !== DASH) begin failures++; $display("[TB] FAIL reset_seg: got %b want %b", seg_out, DASH); end
    checks++; if ({write_mask_out, write_value_out} !== 36'h0) begin failures++; $display("[TB] FAIL reset_wr: got %h/%h want 0", write_mask_out, write_value_out); end
  endtask

  task automatic test_basic_read;
    int cyc;
    logic [6:0] exp;
    logic [3:0] prev, seen;
    do_reset(0, 32'h0000_1234);
    wait_sel(cyc);
    checks++; if (cyc !== 8) begin failures++; $display("[TB] FAIL first_poll_delay: got %0d want 8", cyc); end
    checks++; if (address_out !== ADDR) begin failures++; $display("[TB] FAIL req_addr: got %h want %h", address_out, ADDR); end
    checks++; if (write_mask_out !== 4'b0000) begin failures++; $display("[TB] FAIL req_mask: got %b want 0000", write_mask_out); end
    @(negedge clk);
    checks++; if (sel_out !== 1'b0) begin failures++; $display("[TB] FAIL sel_one_cycle: got %b want 0", sel_out); end
    checks++; if (time_out !== 16'h1234) begin failures++; $display("[TB] FAIL capture_time: got %h want 1234", time_out); end
    checks++; if (valid_out !== 1'b1) begin failures++; $display("[TB] FAIL capture_valid: got %b want 1", valid_out); end
    seen = 4'b0000;
    prev = dig_out;
    for (int i = 0; i < 9; i++) begin
      case (dig_out)
        4'b1110: begin exp = 7'b1100110; seen[0] = 1'b1; end
        4'b1101: begin exp = 7'b1001111; seen[1] = 1'b1; end
        4'b1011: begin exp = 7'b1011011; seen[2] = 1'b1; end
        4'b0111: begin exp = 7'b0000110; seen[3] = 1'b1; end
        default: exp = 7'bxxxxxxx;
      endcase
      checks++; if (seg_out !== exp) begin failures++; $display("[TB] FAIL scan_seg dig=%b: got %b want %b", dig_out, seg_out, exp); end
      if (dig_out != prev) begin
        checks++; if (dig_out !== {prev[2:0], prev[3]}) begin failures++; $display("[TB] FAIL scan_order: got %b after %b want %b", dig_out, prev, {prev[2:0], prev[3]}); end
      end
      prev = dig_out;
      @(negedge clk);
    end
    checks++; if (seen !== 4'hF) begin failures++; $display("[TB] FAIL scan_coverage: got %b want 1111", seen); end
  endtask

  task automatic test_timeout;
    int cyc, n;
    do_reset(100, 32'h0000_1234);
    wait_sel(cyc);
    count_sel(n);
    checks++; if (n !== 4) begin failures++; $display("[TB] FAIL timeout_sel_len: got %0d want 4", n); end
    checks++; if (timeout_err_out !== 1'b1) begin failures++; $display("[TB] FAIL timeout_flag: got %b want 1", timeout_err_out); end
    checks++; if ({valid_out, time_out} !== 17'h0) begin failures++; $display("[TB] FAIL timeout_nocap: got %b/%h want 0/0000", valid_out, time_out); end
    checks++; if (seg_out !== DASH) begin failures++; $display("[TB] FAIL timeout_dash: got %b want %b", seg_out, DASH); end
    wait_sel(cyc);
    checks++; if (cyc !== 8) begin failures++; $display("[TB] FAIL repoll_delay: got %0d want 8", cyc); end
  endtask

  task automatic test_ready_delay(input int delay, input bit expect_capture);
    int cyc, n;
    do_reset(delay, 32'h0000_0512);
    wait_sel(cyc);
    count_sel(n);
    checks++; if (n !== 4) begin failures++; $display("[TB] FAIL delay%0d_sel_len: got %0d want 4", delay, n); end
    checks++; if (timeout_err_out !== !expect_capture) begin failures++; $display("[TB] FAIL delay%0d_terr: got %b want %b", delay, timeout_err_out, !expect_capture); end
    checks++; if (valid_out !== expect_capture) begin failures++; $display("[TB] FAIL delay%0d_valid: got %b want %b", delay, valid_out, expect_capture); end
    checks++; if (time_out !== (expect_capture ? 16'h0512 : 16'h0000)) begin failures++; $display("[TB] FAIL delay%0d_time: got %h", delay, time_out); end
  endtask

  task automatic test_bcd_error;
    int cyc;
    do_reset(0, 32'hFFFF_0959);
    wait_sel(cyc);
    @(negedge clk);
    checks++; if ({valid_out, bcd_err_out, time_out} !== {2'b10, 16'h0959}) begin failures++; $display("[TB] FAIL bcd_first: got v=%b e=%b t=%h want v=1 e=0 t=0959", valid_out, bcd_err_out, time_out); end
    read_value = 32'h0000_0A00;
    wait_sel(cyc);
    @(negedge clk);
    checks++; if (bcd_err_out !== 1'b1) begin failures++; $display("[TB] FAIL bcd_minlo_flag: got %b want 1", bcd_err_out); end
    checks++; if ({valid_out, time_out} !== {1'b1, 16'h0959}) begin failures++; $display("[TB] FAIL bcd_hold: got v=%b t=%h want v=1 t=0959", valid_out, time_out); end
    do_reset(0, 32'h0000_6000);
    wait_sel(cyc);
    @(negedge clk);
    checks++; if ({bcd_err_out, valid_out} !== 2'b10) begin failures++; $display("[TB] FAIL bcd_minhi: got e=%b v=%b want e=1 v=0", bcd_err_out, valid_out); end
  endtask

  task automatic test_reset_mid_request;
    int cyc;
    do_reset(0, 32'h0000_1234);
    wait_sel(cyc);
    ready_delay = 100;
    wait_sel(cyc);
    checks++; if (sel_out !== 1'b1) begin failures++; $display("[TB] FAIL mid_req_sel: got %b want 1", sel_out); end
    reset_n = 1'b0;
    #1;
    checks++; if ({sel_out, address_out} !== 33'h0) begin failures++; $display("[TB] FAIL mid_reset_bus: got %b/%h want 0/0", sel_out, address_out); end
    checks++; if ({valid_out, time_out, timeout_err_out, bcd_err_out} !== 19'h0) begin failures++; $display("[TB] FAIL mid_reset_state: got v=%b t=%h te=%b be=%b", valid_out, time_out, timeout_err_out, bcd_err_out); end
    checks++; if ({dig_out, seg_out} !== {4'b1110, DASH}) begin failures++; $display("[TB] FAIL mid_reset_disp: got %b/%b want 1110/%b", dig_out, seg_out, DASH); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wait_sel(cyc);
    checks++; if (cyc !== 8) begin failures++; $display("[TB] FAIL post_reset_poll: got %0d want 8", cyc); end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_timeout();
    test_ready_delay(3, 1'b1);
    test_ready_delay(4, 1'b0);
    test_bcd_error();
    test_reset_mid_request();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rtc_poller.md
Name: rtc_poller

Overview:
- Bus initiator that periodically reads the time register of an RTC-style memory-bus responder.
- Validates the packed BCD mm:ss value and holds the last good sample.
- Drives a 4-digit multiplexed seven-segment display.
- Sits between the memory bus (as initiator) and the board display pins; flags a timeout when a responder never answers and flags malformed BCD data.

Parameters:
- RTC_ADDR, 32'h0000_8000, byte address of the time register driven on address_out.
- POLL_COUNT, 1000000, clk_in cycles between read requests (minimum 2).
- TIMEOUT, 16, maximum cycles sel_out may stay high without ready_in (minimum 1).
- SCAN_COUNT, 10000, clk_in cycles each digit stays lit (minimum 1).

Ports:
- clk_in  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- address_out  output  32  bus address; RTC_ADDR whenever sel_out=1, else 0.
- sel_out  output  1  bus select/request.
- write_mask_out  output  4  always 4'b0000 (read-only initiator).
- write_value_out  output  32  always 0.
- read_value_in  input  32  responder read data; only bits [15:0] are used.
- ready_in  input  1  responder ready; combinational responders may return it in the same cycle as sel_out.
- time_out  output  16  last valid sample {minHi,minLo,secHi,secLo}.
- valid_out  output  1  high once at least one valid sample has been captured.
- timeout_err_out  output  1  sticky; set on bus timeout.
- bcd_err_out  output  1  sticky; set on malformed data.
- seg_out  output  7  {g,f,e,d,c,b,a}, active high.
- dig_out  output  4  digit enables, active low; [0]=secLo … [3]=minHi.

Behaviour:
- Reset (asynchronous, immediate):
  - sel_out=0, address_out=0.
  - time_out=0, valid_out=0, both error flags=0.
  - FSM=IDLE, poll counter=0, scan counter=0, digit index=0.
  - dig_out=4'b1110; seg_out shows a dash (7'b1000000).
- FSM states: IDLE, REQ.
  - IDLE: poll counter increments each cycle. When it equals POLL_COUNT-1, the counter clears and the next state is REQ. The first sel_out rises POLL_COUNT cycles after reset_n deasserts.
  - REQ: sel_out=1, address_out=RTC_ADDR. A wait counter increments each cycle.
    - On a rising edge with sel_out&ready_in, capture read_value_in[15:0] and go to IDLE. sel_out is therefore high for at least 1 cycle.
    - If the wait counter reaches TIMEOUT-1 without ready_in, set timeout_err_out, leave time_out unchanged and go to IDLE. sel_out was high exactly TIMEOUT cycles.
    - ready_in and the timeout in the same cycle: ready wins and no error is set.
  - The poll counter is held at 0 while in REQ, so polling never overlaps a request.
- ready_in while sel_out=0: ignored.
- read_value_in[31:16]: ignored.
- Capture validation: the sample is valid iff secLo≤9, secHi≤5, minLo≤9, minHi≤5.
  - Valid: time_out is loaded and valid_out is set (sticky until reset).
  - Invalid: set bcd_err_out; time_out and valid_out are unchanged.
- Error flags clear only on reset.
- Display scan (independent of the FSM, runs continuously):
  - Scan counter wraps at SCAN_COUNT-1; on wrap the digit index advances 0→1→2→3→0.
  - dig_out = ~(4'b0001 << index).
  - seg_out = seven-segment decode of time_out nibble[index] when valid_out=1, else dash on all digits.
  - Decode for 0–9: standard patterns (0=7'b0111111, 1=7'b0000110, 5=7'b1101101, 9=7'b1101111). Nibbles 10–15 cannot reach the decoder in normal operation; decode them as blank (7'b0000000).
- Reset asserted mid-request: sel_out drops asynchronously in the same instant and the transaction is abandoned; no capture occurs.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit. No overflow is possible because every counter clears at its terminal value.

Decomposition:
- Package rtc_pkg:
  - typedef enum {IDLE, REQ} poller_state_t.
  - packed struct bcd_time_t {minHi, minLo, secHi, secLo} of 4-bit fields.
  - constants SEG_DASH, SEG_BLANK, and the 10-entry segment table.
- Sub-module bcd_to_7seg: combinational 4-bit→7-bit decoder, instantiated once, fed by the selected nibble.

Test Plan (POLL_COUNT=8, TIMEOUT=4, SCAN_COUNT=2, combinational responder ready=sel):
- Reset release, read data 16'h1234 → sel_out rises at cycle 8 for 1 cycle with address_out=RTC_ADDR and write_mask_out=0; the next cycle time_out=16'h1234 and valid_out=1. Scan dig_out 1110/1101/1011/0111 shows segments for 4, 3, 2, 1.
- Responder with ready tied 0 → sel_out is high exactly 4 cycles, then timeout_err_out=1, time_out stays 0, valid_out=0, and the display shows dashes. The next poll is 8 cycles later.
- Responder with ready delayed 3 cycles → capture on the 4th sel cycle; no timeout_err.
- Responder with ready delayed 4 cycles → timeout_err_out=1 and no capture.
- Valid 16'h0959 then data 16'h0A00 → time_out stays 16'h0959, bcd_err_out=1, valid_out stays 1. Also check 16'h6000 → bcd_err_out=1.
- reset_n pulsed low while sel_out=1 → sel_out=0 immediately, all outputs at reset values, and the next request occurs 8 cycles after release.
